// File: rtl/router_out_arbiter_if.sv
// Bundle between the router's three output FIFOs, the output arbiter and the
// downstream link.
//   master : arbiter side (drives read strobes, downstream byte, grant, abort)
//   slave  : FIFO/downstream side (drives FIFO status/data and dn_ready)
// Signals:
//   vld_out_0..2  FIFO non-empty flags
//   dout0..2      FIFO read data, valid 1 cycle after the matching read_enb
//   dn_ready      downstream credit
//   read_enb_0..2 FIFO read strobes
//   dn_data/dn_valid/dn_sop/dn_eop  downstream byte stream
//   grant         granted FIFO index, 2'b11 = none
//   abort         1-cycle packet-abandon pulse
interface router_out_arbiter_if #(
    parameter int unsigned DATA_W = 8
);
    logic              vld_out_0;
    logic              vld_out_1;
    logic              vld_out_2;
    logic [DATA_W-1:0] dout0;
    logic [DATA_W-1:0] dout1;
    logic [DATA_W-1:0] dout2;
    logic              dn_ready;
    logic              read_enb_0;
    logic              read_enb_1;
    logic              read_enb_2;
    logic [DATA_W-1:0] dn_data;
    logic              dn_valid;
    logic              dn_sop;
    logic              dn_eop;
    logic [1:0]        grant;
    logic              abort;

    modport master (
        input  vld_out_0, vld_out_1, vld_out_2,
        input  dout0, dout1, dout2,
        input  dn_ready,
        output read_enb_0, read_enb_1, read_enb_2,
        output dn_data, dn_valid, dn_sop, dn_eop,
        output grant, abort
    );

    modport slave (
        output vld_out_0, vld_out_1, vld_out_2,
        output dout0, dout1, dout2,
        output dn_ready,
        input  read_enb_0, read_enb_1, read_enb_2,
        input  dn_data, dn_valid, dn_sop, dn_eop,
        input  grant, abort
    );
endinterface

// File: rtl/router_out_arbiter.sv
// Packet-granular 3:1 round-robin arbiter draining the router's output FIFOs
// onto one downstream link. A granted FIFO keeps the link until its whole
// packet (header, len payload bytes, parity) has been forwarded.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     router_out_arbiter_if.master (FIFO status/data in, read strobes,
//           downstream byte stream, grant, abort out)
// Optional feature macro: ARB_TIMEOUT_EN -- abandon a packet after
// TIMEOUT_CYCLES consecutive cycles with the granted FIFO empty mid-packet.
// Without it abort is tied 0 and the arbiter waits indefinitely.
// read_enb_* and dn_data are combinational from registered state and the
// FIFO/downstream inputs (FIFO data returns one cycle after the strobe);
// dn_valid, dn_sop, dn_eop, grant and abort are registered.
module router_out_arbiter #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 30
) (
    input  logic                 clk,
    input  logic                 resetn,
    router_out_arbiter_if.master bus
);
    localparam int unsigned REM_W     = 7;
    localparam logic [1:0]  GRANT_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_LEN  = 2'd2,
        ST_BODY = 2'd3
    } state_t;

    state_t            st;
    logic [1:0]        ptr;
    logic [1:0]        grant_q;
    logic [REM_W-1:0]  rem;
    logic              dn_valid_q;
    logic              dn_sop_q;
    logic              dn_eop_q;

    logic [2:0]        vld_c;
    logic              vld_g_c;
    logic [DATA_W-1:0] dout_g_c;
    logic              rd_en_c;
    logic              pick_vld_c;
    logic [1:0]        pick_c;

    // (a + b) mod 3 for a, b in 0..2
    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = 3'(a) + 3'(b);
        return (s >= 3'd3) ? 2'(s - 3'd3) : 2'(s);
    endfunction

    assign vld_c = {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0};

    // Status and data of the currently granted FIFO
    always_comb begin
        vld_g_c  = 1'b0;
        dout_g_c = '0;
        case (grant_q)
            2'd0: begin vld_g_c = vld_c[0]; dout_g_c = bus.dout0; end
            2'd1: begin vld_g_c = vld_c[1]; dout_g_c = bus.dout1; end
            2'd2: begin vld_g_c = vld_c[2]; dout_g_c = bus.dout2; end
            default: ;
        endcase
    end

    // Round-robin search starting at ptr
    always_comb begin
        pick_vld_c = 1'b0;
        pick_c     = '0;
        for (int k = 0; k < 3; k++) begin
            if (!pick_vld_c && vld_c[mod3_add(ptr, 2'(k))]) begin
                pick_vld_c = 1'b1;
                pick_c     = mod3_add(ptr, 2'(k));
            end
        end
    end

    // Reads only in HDR, or in BODY while bytes remain, with data and credit
    assign rd_en_c = ((st == ST_HDR) || ((st == ST_BODY) && (rem != '0)))
                     && vld_g_c && bus.dn_ready;

    assign bus.read_enb_0 = rd_en_c && (grant_q == 2'd0);
    assign bus.read_enb_1 = rd_en_c && (grant_q == 2'd1);
    assign bus.read_enb_2 = rd_en_c && (grant_q == 2'd2);

    assign bus.dn_data  = dn_valid_q ? dout_g_c : '0;
    assign bus.dn_valid = dn_valid_q;
    assign bus.dn_sop   = dn_sop_q;
    assign bus.dn_eop   = dn_eop_q;
    assign bus.grant    = grant_q;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
    logic             abort_q;
    assign bus.abort = abort_q;
`else
    wire unused_timeout = ^{1'b0, 32'(TIMEOUT_CYCLES)};
    assign bus.abort = 1'b0;
`endif

    // Arbitration FSM and registered downstream flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st         <= ST_IDLE;
            ptr        <= '0;
            grant_q    <= GRANT_NONE;
            rem        <= '0;
            dn_valid_q <= 1'b0;
            dn_sop_q   <= 1'b0;
            dn_eop_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            to_cnt     <= '0;
            abort_q    <= 1'b0;
`endif
        end else begin
            // Every read returns a byte next cycle; the HDR read is the header
            dn_valid_q <= rd_en_c;
            dn_sop_q   <= rd_en_c && (st == ST_HDR);
            dn_eop_q   <= rd_en_c && (st == ST_BODY) && (rem == REM_W'(1));

            case (st)
                ST_IDLE: begin
                    if (pick_vld_c) begin
                        grant_q <= pick_c;
                        st      <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (rd_en_c) st <= ST_LEN;
                end
                ST_LEN: begin
                    // Header is on dout now: payload length plus parity byte
                    rem <= REM_W'(dout_g_c[7:2]) + REM_W'(1);
                    st  <= ST_BODY;
                end
                ST_BODY: begin
                    // rem == 0 means the eop byte is on the link this cycle
                    if (rem == '0) begin
                        ptr     <= mod3_add(grant_q, 2'd1);
                        grant_q <= GRANT_NONE;
                        st      <= ST_IDLE;
                    end else if (rd_en_c) begin
                        rem <= rem - REM_W'(1);
                    end
                end
                default: st <= ST_IDLE;
            endcase

`ifdef ARB_TIMEOUT_EN
            // Starvation watchdog; overrides the FSM update when it fires
            abort_q <= 1'b0;
            if ((st == ST_HDR) || ((st == ST_BODY) && (rem != '0))) begin
                if (vld_g_c) begin
                    to_cnt <= '0;
                end else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    to_cnt  <= '0;
                    abort_q <= 1'b1;
                    ptr     <= mod3_add(grant_q, 2'd1);
                    grant_q <= GRANT_NONE;
                    st      <= ST_IDLE;
                end else begin
                    to_cnt <= to_cnt + CNT_W'(1);
                end
            end else begin
                to_cnt <= '0;
            end
`endif
        end
    end
endmodule
